// File: rtl/conversor_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM encoding, data width and the double-dabble correction constants.
package conversor_bcd_seq_pkg;

  localparam int DATA_W = 8;
  localparam int BCD_W  = 4;
  localparam int CONT_W = 3;

  localparam logic [BCD_W-1:0] BCD_CORRECAO = 4'd3;
  localparam logic [BCD_W-1:0] BCD_LIMIAR   = 4'd5;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    FIM      = 2'd2
  } estado_t;

endpackage

// File: rtl/conversor_bcd_seq_ajuste_bcd_digito.sv
// Double-dabble correction for one BCD nibble: add 3 when the digit is 5 or more,
// so that the following left shift carries correctly into the next decade.
module ajuste_bcd_digito
  import conversor_bcd_seq_pkg::*;
(
  input  logic [BCD_W-1:0] digito,
  output logic [BCD_W-1:0] ajustado
);

  assign ajustado = (digito >= BCD_LIMIAR) ? (digito + BCD_CORRECAO) : digito;

endmodule

// File: rtl/conversor_bcd_seq.sv
// Sequential 8-bit to 3-digit BCD converter (double dabble, one bit per cycle)
// with optional two's-complement input; fixed 9-cycle latency to the pronto pulse.
module conversor_bcd_seq
  import conversor_bcd_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] valor,
  input  logic              iniciar,
  input  logic              modo_sinal,
  output logic              ocupado,
  output logic              pronto,
  output logic [BCD_W-1:0]  centenas,
  output logic [BCD_W-1:0]  dezenas,
  output logic [BCD_W-1:0]  unidades,
  output logic              negativo
);

  // {sign, magnitude}; negating 0x80 yields 0x80, which read unsigned is 128.
  function automatic logic [DATA_W:0] extrai_magnitude(input logic [DATA_W-1:0] v,
                                                       input logic              com_sinal);
    logic signed [DATA_W-1:0] v_s;
    v_s = signed'(v);
    if (com_sinal && (v_s < 0))
      return {1'b1, (~v) + DATA_W'(1)};
    return {1'b0, v};
  endfunction

  estado_t                 estado, estado_prox;
  logic [DATA_W-1:0]       mag;
  logic [3*BCD_W-1:0]      bcd;
  logic [3*BCD_W-1:0]      bcd_aj;
  logic [CONT_W-1:0]       cont;
  logic                    sinal;

  ajuste_bcd_digito u_aj_unidades (.digito(bcd[BCD_W-1:0]),         .ajustado(bcd_aj[BCD_W-1:0]));
  ajuste_bcd_digito u_aj_dezenas  (.digito(bcd[2*BCD_W-1:BCD_W]),   .ajustado(bcd_aj[2*BCD_W-1:BCD_W]));
  ajuste_bcd_digito u_aj_centenas (.digito(bcd[3*BCD_W-1:2*BCD_W]), .ajustado(bcd_aj[3*BCD_W-1:2*BCD_W]));

  assign ocupado = (estado == CONVERTE) || (estado == FIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) estado <= OCIOSO;
    else     estado <= estado_prox;
  end

  always_comb begin
    estado_prox = estado;
    case (estado)
      OCIOSO:   if (iniciar) estado_prox = CONVERTE;
      CONVERTE: if (cont == CONT_W'(7)) estado_prox = FIM;
      FIM:      estado_prox = OCIOSO;
      default:  estado_prox = OCIOSO;
    endcase
  end

  // Work registers and held result; everything clears on reset so an aborted
  // conversion leaves no trace.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag      <= '0;
      bcd      <= '0;
      cont     <= '0;
      sinal    <= 1'b0;
      centenas <= '0;
      dezenas  <= '0;
      unidades <= '0;
      negativo <= 1'b0;
      pronto   <= 1'b0;
    end else begin
      pronto <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (iniciar) begin
            {sinal, mag} <= extrai_magnitude(valor, modo_sinal);
            bcd          <= '0;
            cont         <= '0;
          end
        end
        CONVERTE: begin
          {bcd, mag} <= {bcd_aj[3*BCD_W-2:0], mag, 1'b0};
          cont       <= cont + CONT_W'(1);
        end
        FIM: begin
          centenas <= bcd[3*BCD_W-1:2*BCD_W];
          dezenas  <= bcd[2*BCD_W-1:BCD_W];
          unidades <= bcd[BCD_W-1:0];
          negativo <= sinal;
          pronto   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conversor_bcd_seq.sv
// Bench for conversor_bcd_seq: decimal reference model with a cycle countdown,
// per-cycle comparison of all outputs, directed literal cases and randomized sweep.
module tb_conversor_bcd_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] valor = 8'h00;
  logic       iniciar = 1'b0;
  logic       modo_sinal = 1'b0;
  logic       ocupado, pronto, negativo;
  logic [3:0] centenas, dezenas, unidades;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pronto = 0;
  int cyc      = 0;
  int last_pronto_cyc = -1;
  int pronto_interval = 0;

  conversor_bcd_seq dut (
    .clk(clk), .rst(rst), .valor(valor), .iniciar(iniciar), .modo_sinal(modo_sinal),
    .ocupado(ocupado), .pronto(pronto), .centenas(centenas), .dezenas(dezenas),
    .unidades(unidades), .negativo(negativo)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
    end
  endfunction

  // Expected {sign, hundreds, tens, units} straight from decimal arithmetic.
  function automatic logic [12:0] decimal_ref(input logic [7:0] v, input logic m);
    int mag;
    logic neg;
    neg = m && (v >= 8'd128);
    mag = neg ? (256 - int'(v)) : int'(v);
    return {neg, 4'(mag / 100), 4'((mag / 10) % 10), 4'(mag % 10)};
  endfunction

  // Reference: a start is accepted only when no conversion is pending; the
  // result appears nine edges later and is held.
  int          rem = 0;
  logic [12:0] pend = '0;
  logic [12:0] e_res = '0;
  logic        e_pronto = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rem      <= 0;
      e_res    <= '0;
      e_pronto <= 1'b0;
    end else begin
      e_pronto <= 1'b0;
      if (rem == 0) begin
        if (iniciar) begin
          pend <= decimal_ref(valor, modo_sinal);
          rem  <= 9;
        end
      end else begin
        rem <= rem - 1;
        if (rem == 1) begin
          e_res    <= pend;
          e_pronto <= 1'b1;
        end
      end
    end
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    chk("cycle", {1'b0, ocupado, pronto, negativo, centenas, dezenas, unidades},
        {1'b0, (rem != 0), e_pronto, e_res});
    chk("bcd_legal", {15'b0, (centenas <= 4'd2) && (dezenas <= 4'd9) && (unidades <= 4'd9)}, 16'd1);
    if (pronto) begin
      n_pronto++;
      if (last_pronto_cyc >= 0) pronto_interval = cyc - last_pronto_cyc;
      last_pronto_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_and_wait(input logic [7:0] v, input logic m, output int lat);
    valor = v;
    modo_sinal = m;
    iniciar = 1'b1;
    @(posedge clk);
    #2;
    iniciar = 1'b0;
    lat = 0;
    while (!pronto && lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  function automatic logic [15:0] shown();
    return {3'b0, negativo, centenas, dezenas, unidades};
  endfunction

  initial begin
    int lat;
    int p0;

    rst = 1'b1;
    #1;
    chk("reset_outputs", {1'b0, ocupado, pronto, negativo, centenas, dezenas, unidades}, 16'h0000);
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    start_and_wait(8'hFF, 1'b0, lat);
    chk("ff_latency", 16'(lat), 16'd9);
    chk("ff_digits", shown(), 16'h0255);
    repeat (3) tick();

    start_and_wait(8'h80, 1'b1, lat);
    chk("80_latency", 16'(lat), 16'd9);
    chk("80_digits", shown(), 16'h1128);
    repeat (3) tick();

    start_and_wait(8'hF6, 1'b1, lat);
    chk("f6_digits", shown(), 16'h1010);
    repeat (3) tick();

    // A second start four edges into a conversion must be ignored.
    p0 = n_pronto;
    valor = 8'h2A; modo_sinal = 1'b0; iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    repeat (3) tick();
    valor = 8'h63; iniciar = 1'b1;
    tick();
    iniciar = 1'b0; valor = 8'h00;
    repeat (20) tick();
    chk("ignored_start_pronto_count", 16'(n_pronto - p0), 16'd1);
    chk("ignored_start_digits", shown(), 16'h0042);

    // Reset in the middle of a conversion aborts it immediately.
    valor = 8'h99; iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    repeat (5) tick();
    p0 = n_pronto;
    rst = 1'b1;
    #1;
    chk("abort_outputs", {1'b0, ocupado, pronto, negativo, centenas, dezenas, unidades}, 16'h0000);
    repeat (2) tick();
    rst = 1'b0;
    repeat (12) tick();
    chk("abort_no_pronto", 16'(n_pronto - p0), 16'd0);
    start_and_wait(8'h07, 1'b0, lat);
    chk("after_reset_latency", 16'(lat), 16'd9);
    chk("after_reset_digits", shown(), 16'h0007);
    repeat (3) tick();

    // Continuous start request: one result every ten cycles.
    valor = 8'h00; modo_sinal = 1'b0; iniciar = 1'b1;
    repeat (25) tick();
    chk("continuous_zero", shown(), 16'h0000);
    chk("continuous_interval", 16'(pronto_interval), 16'd10);
    valor = 8'h64;
    repeat (30) tick();
    chk("continuous_100", shown(), 16'h0100);
    chk("continuous_interval2", 16'(pronto_interval), 16'd10);
    iniciar = 1'b0;
    repeat (12) tick();

    // Full sweep, both modes, with random input noise during each conversion.
    for (int m = 0; m < 2; m++) begin
      for (int v = 0; v < 256; v++) begin
        valor = 8'(v); modo_sinal = m[0]; iniciar = 1'b1;
        for (int k = 0; k < 9; k++) begin
          tick();
          iniciar    = 1'($urandom_range(0, 1));
          valor      = 8'($urandom);
          modo_sinal = 1'($urandom_range(0, 1));
        end
        tick();
      end
    end
    iniciar = 1'b0;
    repeat (12) tick();
    chk("sweep_last_digits", shown(), 16'h1001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

endmodule
